// File: rtl/operand_sel_pipe.sv
// operand_sel_pipe
//   Selects one of NSRC packed operand sources by 'sel' and passes the chosen
//   operand through a valid/ready output stage with a skid register. The
//   input side can take a beat every cycle. in_ready is registered, so it
//   does not depend combinationally on out_ready. A select value at or
//   beyond NSRC yields data 0 with out_err set.
//
// Parameters
//   WIDTH  operand width in bits (1..64)
//   NSRC   number of operand sources (2..2**SELW)
//   SELW   select width
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   src        packed sources, source k at [k*WIDTH +: WIDTH]
//   sel        source select
//   in_valid   producer offers src/sel
//   in_ready   block can accept a beat (registered)
//   out_data   selected operand
//   out_err    beat carried an out-of-range select
//   out_valid  out_data/out_err hold a beat
//   out_ready  consumer takes the beat
module operand_sel_pipe #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 3,
  parameter int SELW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSRC*WIDTH-1:0] src,
  input  logic [SELW-1:0]       sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] out_data_p0;
  logic             out_err_p0;
  logic             vld_p0;
  logic             in_ready_q;
  logic [WIDTH-1:0] skid_data_p0;
  logic             skid_err_p0;

  logic             acc;
  logic             hand;
  logic             load_out_in;
  logic             load_out_skid;
  logic             load_skid;
  logic [WIDTH:0]   res;

  // Returns {err, data}. Every select that matches no source falls through
  // to the default of data 0 with the error flag set.
  function automatic logic [WIDTH:0] resolve(
    input logic [NSRC*WIDTH-1:0] s,
    input logic [SELW-1:0]       k_sel
  );
    logic [WIDTH:0] r;
    r = {1'b1, {WIDTH{1'b0}}};
    for (int k = 0; k < NSRC; k++) begin
      if (k_sel == SELW'(k)) begin
        r = {1'b0, s[k*WIDTH +: WIDTH]};
      end
    end
    return r;
  endfunction

  assign acc  = in_valid & in_ready_q;
  assign hand = vld_p0 & out_ready;
  assign res  = resolve(src, sel);

  always_comb begin
    state_nxt     = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (acc) begin
          load_out_in = 1'b1;
          state_nxt   = ONE;
        end
      end
      ONE: begin
        if (hand && acc) begin
          load_out_in = 1'b1;
        end else if (hand) begin
          state_nxt = EMPTY;
        end else if (acc) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (hand) begin
          load_out_skid = 1'b1;
          state_nxt     = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Stage p0: selection is resolved at accept time and captured into OUT
  // or SKID, so later changes on src/sel never touch a stored beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      vld_p0       <= 1'b0;
      in_ready_q   <= 1'b1;
      out_data_p0  <= '0;
      out_err_p0   <= 1'b0;
      skid_data_p0 <= '0;
      skid_err_p0  <= 1'b0;
    end else begin
      state      <= state_nxt;
      vld_p0     <= (state_nxt != EMPTY);
      in_ready_q <= (state_nxt != FULL);
      if (load_out_in) begin
        out_data_p0 <= res[WIDTH-1:0];
        out_err_p0  <= res[WIDTH];
      end else if (load_out_skid) begin
        out_data_p0 <= skid_data_p0;
        out_err_p0  <= skid_err_p0;
      end
      if (load_skid) begin
        skid_data_p0 <= res[WIDTH-1:0];
        skid_err_p0  <= res[WIDTH];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = vld_p0;
  assign out_data  = out_data_p0;
  assign out_err   = out_err_p0;

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Testbench for operand_sel_pipe: directed table and hand-written sequences
// on the default configuration, and a randomized run of WIDTH=32/NSRC=4
// against a queue-based reference model.
module tb_operand_sel_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default configuration instance
  logic [47:0] src0;
  logic [1:0]  sel0;
  logic        iv0, ir0, oe0, ov0, or0;
  logic [15:0] od0;

  operand_sel_pipe #(.WIDTH(16), .NSRC(3), .SELW(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .src(src0), .sel(sel0), .in_valid(iv0),
    .in_ready(ir0), .out_data(od0), .out_err(oe0), .out_valid(ov0),
    .out_ready(or0)
  );

  // wide configuration instance
  localparam int NSRC1 = 4;
  logic [127:0] src1;
  logic [1:0]   sel1;
  logic         iv1, ir1, oe1, ov1, or1;
  logic [31:0]  od1;

  operand_sel_pipe #(.WIDTH(32), .NSRC(NSRC1), .SELW(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .src(src1), .sel(sel1), .in_valid(iv1),
    .in_ready(ir1), .out_data(od1), .out_err(oe1), .out_valid(ov1),
    .out_ready(or1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] data;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } beat_t;

  function automatic beat_t model_sel(input logic [127:0] s, input logic [1:0] k);
    beat_t b;
    int    idx;
    idx = int'(k);
    if (idx < NSRC1) begin
      b.d = s[idx*32 +: 32];
      b.e = 1'b0;
    end else begin
      b.d = '0;
      b.e = 1'b1;
    end
    return b;
  endfunction

  vec_t  tbl[4];
  beat_t q[$];

  initial begin
    tbl[0] = '{sel: 2'd0, data: 16'h0000, err: 1'b0};
    tbl[1] = '{sel: 2'd1, data: 16'h0001, err: 1'b0};
    tbl[2] = '{sel: 2'd2, data: 16'h0002, err: 1'b0};
    tbl[3] = '{sel: 2'd3, data: 16'h0000, err: 1'b1};

    rst_n = 1'b0;
    src0 = '0; sel0 = '0; iv0 = 1'b0; or0 = 1'b1;
    src1 = '0; sel1 = '0; iv1 = 1'b0; or1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(ov0), 64'd0);
    check("rst_in_ready",  64'(ir0), 64'd1);
    check("rst_out_data",  64'(od0), 64'd0);
    check("rst_out_err",   64'(oe0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // source select table
    src0 = {16'h0002, 16'h0001, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sel0 = tbl[i].sel;
      iv0  = 1'b1;
      @(posedge clk);
      #1;
      check("sel_valid", 64'(ov0), 64'd1);
      check("sel_data",  64'(od0), 64'(tbl[i].data));
      check("sel_err",   64'(oe0), 64'(tbl[i].err));
      @(negedge clk);
      iv0 = 1'b0;
      @(posedge clk);
      #1;
      check("sel_drained", 64'(ov0), 64'd0);
    end

    // streaming
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      src0 = {16'h0, 16'(16'h1000 + i), 16'h0};
      sel0 = 2'd1;
      iv0  = 1'b1;
      @(posedge clk);
      #1;
      check("stream_ready", 64'(ir0), 64'd1);
      check("stream_valid", 64'(ov0), 64'd1);
      check("stream_data",  64'(od0), 64'(16'h1000 + i));
    end
    @(negedge clk);
    iv0 = 1'b0;
    @(posedge clk);
    #1;
    check("stream_empty", 64'(ov0), 64'd0);

    // backpressure
    @(negedge clk);
    or0 = 1'b0; sel0 = 2'd0; src0 = {32'h0, 16'h00a1}; iv0 = 1'b1;
    @(posedge clk);
    #1;
    check("bp_ready1", 64'(ir0), 64'd1);
    @(negedge clk);
    src0 = {32'h0, 16'h00b2};
    @(posedge clk);
    #1;
    check("bp_ready_full", 64'(ir0), 64'd0);
    check("bp_head", 64'(od0), 64'h00a1);
    @(negedge clk);
    src0 = {32'h0, 16'h00c3};
    @(posedge clk);
    #1;
    check("bp_held_ready", 64'(ir0), 64'd0);
    check("bp_held_data", 64'(od0), 64'h00a1);
    @(negedge clk);
    or0 = 1'b1;
    @(posedge clk);
    #1;
    check("bp_drain_b", 64'(od0), 64'h00b2);
    check("bp_ready_back", 64'(ir0), 64'd1);
    @(posedge clk);
    #1;
    check("bp_drain_c", 64'(od0), 64'h00c3);
    check("bp_c_valid", 64'(ov0), 64'd1);
    @(negedge clk);
    iv0 = 1'b0;
    @(posedge clk);
    #1;
    check("bp_empty", 64'(ov0), 64'd0);

    // hold stability
    @(negedge clk);
    or0 = 1'b0; src0 = {32'h0, 16'h5a5a}; sel0 = 2'd0; iv0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      src0 = {$urandom, $urandom};
      sel0 = 2'($urandom);
      @(posedge clk);
      #1;
      check("hold_data", 64'(od0), 64'h5a5a);
      check("hold_err", 64'(oe0), 64'd0);
    end
    @(negedge clk);
    or0 = 1'b1;
    @(posedge clk);
    #1;
    check("hold_drained", 64'(ov0), 64'd0);

    // reset mid-operation from FULL
    @(negedge clk);
    or0 = 1'b0; sel0 = 2'd0; src0 = {32'h0, 16'h0011}; iv0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    src0 = {32'h0, 16'h0022};
    @(posedge clk);
    #1;
    check("mid_full", 64'(ir0), 64'd0);
    @(negedge clk);
    iv0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(ov0), 64'd0);
    check("mid_rst_ready", 64'(ir0), 64'd1);
    check("mid_rst_data",  64'(od0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    or0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("mid_no_stale", 64'(ov0), 64'd0);
    end
    @(negedge clk);
    src0 = {32'h0, 16'h0033}; iv0 = 1'b1;
    @(posedge clk);
    #1;
    check("mid_first_valid", 64'(ov0), 64'd1);
    check("mid_first_data", 64'(od0), 64'h0033);
    @(negedge clk);
    iv0 = 1'b0;
    @(posedge clk);
    #1;
    check("mid_after_empty", 64'(ov0), 64'd0);

    // randomized sweep on the wide instance
    begin
      int    pushed;
      int    cyc;
      logic  acc;
      logic  hand;
      beat_t exp_b;
      pushed = 0;
      cyc    = 0;
      while (pushed < 10000 && cyc < 40000) begin
        @(negedge clk);
        cyc++;
        check("rnd_valid", 64'(ov1), 64'(q.size() > 0));
        check("rnd_ready", 64'(ir1), 64'(q.size() < 2));
        if (q.size() > 0) begin
          exp_b = q[0];
          check("rnd_data", 64'(od1), 64'(exp_b.d));
          check("rnd_err",  64'(oe1), 64'(exp_b.e));
        end
        iv1  = ($urandom_range(3) != 0);
        or1  = ($urandom_range(3) != 0);
        sel1 = 2'($urandom);
        src1 = {$urandom, $urandom, $urandom, $urandom};
        acc  = iv1 && (q.size() < 2);
        hand = (q.size() > 0) && or1;
        @(posedge clk);
        if (hand) void'(q.pop_front());
        if (acc) begin
          q.push_back(model_sel(src1, sel1));
          pushed++;
        end
      end
      total++;
      if (pushed < 10000) begin
        bad++;
        $display("FAIL rnd_budget: got %0d beats want %0d", pushed, 10000);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
